// File: rtl/pwm_pkg.sv
// Shared widths and reset constants for the PWM time-base slice.
// Reset constants are 64 bits wide and sliced to the instance width by users.
package pwm_pkg;

    localparam int WIDTH_DEF     = 16;
    localparam int PSC_WIDTH_DEF = 16;

    localparam logic [63:0] PERIOD_RST = '1;
    localparam logic [63:0] CCR_RST    = '0;
    localparam logic [63:0] PSC_RST    = '0;

endpackage

// File: rtl/pwm_prescaler.sv
// Prescaler: psc_cnt runs 0..psc_act, tick is combinational, state updates on the next edge.
// No backpressure; enable low freezes the count and clear forces it to 0.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PSC_WIDTH = PSC_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 load,
    input  logic [PSC_WIDTH-1:0] load_val,
    output logic                 tick
);

    logic [PSC_WIDTH-1:0] psc_cnt_q, psc_cnt_d;
    logic [PSC_WIDTH-1:0] psc_act_q, psc_act_d;

    always_comb begin
        tick      = enable && (psc_cnt_q == psc_act_q);
        psc_cnt_d = psc_cnt_q;
        if (clear || tick) begin
            psc_cnt_d = '0;
        end else if (enable) begin
            psc_cnt_d = psc_cnt_q + PSC_WIDTH'(1);
        end
        psc_act_d = load ? load_val : psc_act_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psc_cnt_q <= '0;
            psc_act_q <= PSC_RST[PSC_WIDTH-1:0];
        end else begin
            psc_cnt_q <= psc_cnt_d;
            psc_act_q <= psc_act_d;
        end
    end

endmodule

// File: rtl/pwm_timebase.sv
// PWM time base: counter 0..PERIOD-1 with buffered PSC/PERIOD/CCR transferred on update events.
// All outputs registered; wrap results and UPDATE_EVT appear one cycle after the wrap edge.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int PSC_WIDTH = PSC_WIDTH_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ENABLE,
    input  logic                 PRELOAD_EN,
    input  logic                 WR_PSC,
    input  logic                 WR_PERIOD,
    input  logic                 WR_CCR,
    input  logic [PSC_WIDTH-1:0] PSC_IN,
    input  logic [WIDTH-1:0]     PERIOD_IN,
    input  logic [WIDTH-1:0]     CCR_IN,
    input  logic                 FORCE_UPDATE,
    output logic [WIDTH-1:0]     CNT,
    output logic [WIDTH-1:0]     CCR,
    output logic [WIDTH-1:0]     PERIOD,
    output logic                 UPDATE_EVT
);

    logic [WIDTH-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     ccr_q, ccr_d;
    logic [WIDTH-1:0]     period_q, period_d;
    logic                 update_evt_q, update_evt_d;
    logic [PSC_WIDTH-1:0] psc_buf_q, psc_buf_d;
    logic [WIDTH-1:0]     period_buf_q, period_buf_d;
    logic [WIDTH-1:0]     ccr_buf_q, ccr_buf_d;
    logic                 tick, wrap, upd, psc_load;

    pwm_prescaler #(.PSC_WIDTH(PSC_WIDTH)) u_prescaler (
        .clk      (CLK),
        .rst      (RST),
        .enable   (ENABLE),
        .clear    (FORCE_UPDATE),
        .load     (psc_load),
        .load_val (psc_buf_d),
        .tick     (tick)
    );

    always_comb begin
        // >= rather than == so an immediate period shrink below cnt still wraps
        wrap = tick && ((period_q == '0) || (cnt_q >= period_q - WIDTH'(1)));
        upd  = wrap || FORCE_UPDATE;

        psc_buf_d    = WR_PSC    ? PSC_IN    : psc_buf_q;
        period_buf_d = WR_PERIOD ? PERIOD_IN : period_buf_q;
        ccr_buf_d    = WR_CCR    ? CCR_IN    : ccr_buf_q;

        // Loading from the next buffer value gives write/update bypass for free
        psc_load = upd || (WR_PSC && !PRELOAD_EN);
        period_d = (upd || (WR_PERIOD && !PRELOAD_EN)) ? period_buf_d : period_q;
        ccr_d    = (upd || (WR_CCR    && !PRELOAD_EN)) ? ccr_buf_d    : ccr_q;

        cnt_d = cnt_q;
        if (FORCE_UPDATE || wrap) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
        update_evt_d = upd;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q        <= '0;
            ccr_q        <= CCR_RST[WIDTH-1:0];
            period_q     <= PERIOD_RST[WIDTH-1:0];
            update_evt_q <= 1'b0;
            psc_buf_q    <= PSC_RST[PSC_WIDTH-1:0];
            period_buf_q <= PERIOD_RST[WIDTH-1:0];
            ccr_buf_q    <= CCR_RST[WIDTH-1:0];
        end else begin
            cnt_q        <= cnt_d;
            ccr_q        <= ccr_d;
            period_q     <= period_d;
            update_evt_q <= update_evt_d;
            psc_buf_q    <= psc_buf_d;
            period_buf_q <= period_buf_d;
            ccr_buf_q    <= ccr_buf_d;
        end
    end

    assign CNT        = cnt_q;
    assign CCR        = ccr_q;
    assign PERIOD     = period_q;
    assign UPDATE_EVT = update_evt_q;

endmodule

// File: tb/tb_pwm_timebase.sv
// Bench for pwm_timebase: directed scenarios with fixed expectations, then random traffic
// checked every cycle against a cycle-level behavioural model of the timer.
module tb_pwm_timebase;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        preload = 1'b0;
    logic        wr_psc = 1'b0;
    logic        wr_period = 1'b0;
    logic        wr_ccr = 1'b0;
    logic [15:0] psc_in = '0;
    logic [15:0] period_in = '0;
    logic [15:0] ccr_in = '0;
    logic        force_update = 1'b0;
    logic [15:0] cnt, ccr, period;
    logic        evt;

    int n_chk = 0;
    int n_pass = 0;

    // Behavioural model state
    logic [15:0] m_cnt = '0, m_ccr = '0, m_period = '1, m_psc = '0, m_pcnt = '0;
    logic [15:0] b_psc = '0, b_period = '1, b_ccr = '0;
    logic        m_evt = 1'b0;

    pwm_timebase #(.WIDTH(16), .PSC_WIDTH(16)) dut (
        .CLK          (clk),
        .RST          (rst),
        .ENABLE       (enable),
        .PRELOAD_EN   (preload),
        .WR_PSC       (wr_psc),
        .WR_PERIOD    (wr_period),
        .WR_CCR       (wr_ccr),
        .PSC_IN       (psc_in),
        .PERIOD_IN    (period_in),
        .CCR_IN       (ccr_in),
        .FORCE_UPDATE (force_update),
        .CNT          (cnt),
        .CCR          (ccr),
        .PERIOD       (period),
        .UPDATE_EVT   (evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        else n_pass++;
    endtask

    // One rising edge of the timer described from its rules.
    task automatic model_edge();
        bit tick, wrap, upd;
        if (rst) begin
            m_cnt = 0; m_pcnt = 0; m_evt = 0;
            m_ccr = 0; b_ccr = 0; m_period = 16'hFFFF; b_period = 16'hFFFF; m_psc = 0; b_psc = 0;
            return;
        end
        tick = enable && (m_pcnt == m_psc);
        wrap = tick && ((m_period == 0) || (m_cnt >= m_period - 16'd1));
        upd  = wrap || force_update;
        if (wr_psc)    b_psc    = psc_in;
        if (wr_period) b_period = period_in;
        if (wr_ccr)    b_ccr    = ccr_in;
        if (upd) begin
            m_psc = b_psc; m_period = b_period; m_ccr = b_ccr;
        end else if (!preload) begin
            if (wr_psc)    m_psc    = psc_in;
            if (wr_period) m_period = period_in;
            if (wr_ccr)    m_ccr    = ccr_in;
        end
        if (force_update || tick) m_pcnt = 0;
        else if (enable)          m_pcnt = m_pcnt + 16'd1;
        if (force_update || wrap) m_cnt = 0;
        else if (tick)            m_cnt = m_cnt + 16'd1;
        m_evt = upd;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("cnt", cnt, m_cnt);
        chk("ccr", ccr, m_ccr);
        chk("period", period, m_period);
        chk("evt", evt, m_evt);
        rst = 0; wr_psc = 0; wr_period = 0; wr_ccr = 0; force_update = 0;
    endtask

    initial begin
        cycle();
        chk("rst_cnt", cnt, 0);
        chk("rst_ccr", ccr, 0);
        chk("rst_period", period, 16'hFFFF);
        chk("rst_evt", evt, 0);

        // Period 4, no prescale
        wr_period = 1; period_in = 4; wr_ccr = 1; ccr_in = 2; wr_psc = 1; psc_in = 0;
        cycle();
        chk("t1_period", period, 4);
        chk("t1_ccr", ccr, 2);
        enable = 1;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            chk("t1_cnt", cnt, i % 4);
            chk("t1_evt", evt, (i % 4) == 0);
        end

        // Prescale by 3, period 3
        enable = 0; wr_psc = 1; psc_in = 2; wr_period = 1; period_in = 3;
        cycle();
        enable = 1;
        for (int i = 1; i <= 18; i++) begin
            cycle();
            chk("t2_cnt", cnt, (i / 3) % 3);
            chk("t2_evt", evt, (i % 9) == 0);
        end

        // Buffered CCR write mid-period
        enable = 0; wr_psc = 1; psc_in = 0; wr_period = 1; period_in = 8;
        cycle();
        preload = 1; enable = 1;
        repeat (3) cycle();
        chk("t3_cnt3", cnt, 3);
        wr_ccr = 1; ccr_in = 5;
        for (int i = 1; i <= 5; i++) begin
            cycle();
            chk("t3_cnt", cnt, (3 + i) % 8);
            chk("t3_ccr", ccr, (i == 5) ? 5 : 2);
            chk("t3_evt", evt, i == 5);
        end

        // Immediate period shrink below the current count
        preload = 0; enable = 0; wr_period = 1; period_in = 10;
        cycle();
        force_update = 1;
        cycle();
        chk("t4_force_evt", evt, 1);
        enable = 1;
        repeat (7) cycle();
        chk("t4_cnt7", cnt, 7);
        enable = 0; wr_period = 1; period_in = 5;
        cycle();
        chk("t4_period", period, 5);
        chk("t4_hold", cnt, 7);
        enable = 1;
        cycle();
        chk("t4_wrap_cnt", cnt, 0);
        chk("t4_wrap_evt", evt, 1);

        // Force update while disabled
        enable = 0; wr_period = 1; period_in = 10;
        cycle();
        enable = 1;
        repeat (6) cycle();
        chk("t5_cnt6", cnt, 6);
        enable = 0; preload = 1; wr_ccr = 1; ccr_in = 7;
        cycle();
        chk("t5_ccr_old", ccr, 5);
        force_update = 1;
        cycle();
        chk("t5_cnt", cnt, 0);
        chk("t5_ccr", ccr, 7);
        chk("t5_period", period, 10);
        chk("t5_evt", evt, 1);
        cycle();
        chk("t5_evt_once", evt, 0);
        chk("t5_cnt_hold", cnt, 0);

        // Period 0, then reset mid-count with other strobes active
        preload = 0; wr_period = 1; period_in = 0;
        cycle();
        enable = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t6_cnt", cnt, 0);
            chk("t6_evt", evt, 1);
        end
        wr_period = 1; period_in = 10;
        cycle();
        repeat (3) cycle();
        chk("t6_cnt3", cnt, 3);
        rst = 1; force_update = 1; wr_ccr = 1; ccr_in = 9;
        cycle();
        chk("t6_rst_cnt", cnt, 0);
        chk("t6_rst_ccr", ccr, 0);
        chk("t6_rst_period", period, 16'hFFFF);
        chk("t6_rst_evt", evt, 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 199) == 0);
            enable       = ($urandom_range(0, 9) != 0);
            preload      = 1'($urandom_range(0, 1));
            wr_psc       = preload && ($urandom_range(0, 15) == 0);
            psc_in       = 16'($urandom_range(0, 3));
            wr_period    = ($urandom_range(0, 9) == 0);
            period_in    = 16'($urandom_range(0, 12));
            wr_ccr       = ($urandom_range(0, 7) == 0);
            ccr_in       = 16'($urandom_range(0, 15));
            force_update = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
